// File: rtl/dnn_pkg.sv
// Shared types and helpers for the DNN datapath blocks.
package dnn_pkg;

    typedef enum logic [0:0] {
        S_FILL,
        S_PEND
    } deser_state_t;

    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/deser_collector.sv
// Word collector: gathers up to depth words into a slot array, then holds the
// completed frame (done_o) until the output stage takes it (take_i).
module deser_collector
    import dnn_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 5,
    localparam int unsigned CntW = count_width(depth)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     word_valid_i,
    output logic                     word_ready_o,
    input  logic [width-1:0]         word_data_i,
    input  logic                     word_last_i,
    output logic                     done_o,
    input  logic                     take_i,
    output logic [depth*width-1:0]   frame_o,
    output logic [CntW-1:0]          count_o
);

    deser_state_t             state_q, state_d;
    logic [CntW-1:0]          cnt_q, cnt_d;
    logic [depth*width-1:0]   slots_q, slots_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slots_d = slots_q;
        unique case (state_q)
            S_FILL: begin
                if (word_valid_i) begin
                    for (int k = 0; k < int'(depth); k++) begin
                        if (cnt_q == CntW'(k)) begin
                            slots_d[k*width +: width] = word_data_i;
                        end
                    end
                    cnt_d = cnt_q + CntW'(1);
                    if (word_last_i || (cnt_q == CntW'(depth - 1))) begin
                        state_d = S_PEND;
                    end
                end
            end
            S_PEND: begin
                // Clearing on take keeps unused slots of the next short frame at zero.
                if (take_i) begin
                    state_d = S_FILL;
                    cnt_d   = '0;
                    slots_d = '0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FILL;
            cnt_q   <= '0;
            slots_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slots_q <= slots_d;
        end
    end

    assign word_ready_o = (state_q == S_FILL);
    assign done_o       = (state_q == S_PEND);
    assign frame_o      = slots_q;
    assign count_o      = cnt_q;

endmodule

// File: rtl/deser_buffer.sv
// Serial-to-parallel frame buffer: collector plus one output register, so a new
// frame can fill while the previous one waits for the consumer.
module deser_buffer
    import dnn_pkg::*;
#(
    parameter int unsigned width = 8,
    parameter int unsigned depth = 5,
    localparam int unsigned CntW = count_width(depth)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [width-1:0]         in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [depth*width-1:0]   out_data,
    output logic [CntW-1:0]          out_count
);

    logic                     done;
    logic                     take;
    logic [depth*width-1:0]   frame;
    logic [CntW-1:0]          count;

    logic                     out_valid_q, out_valid_d;
    logic [depth*width-1:0]   out_data_q, out_data_d;
    logic [CntW-1:0]          out_count_q, out_count_d;

    deser_collector #(
        .width(width),
        .depth(depth)
    ) u_collector (
        .clk         (clk),
        .reset       (reset),
        .word_valid_i(in_valid),
        .word_ready_o(in_ready),
        .word_data_i (in_data),
        .word_last_i (in_last),
        .done_o      (done),
        .take_i      (take),
        .frame_o     (frame),
        .count_o     (count)
    );

    // Output register is free when empty or being drained on this edge.
    assign take = done && (!out_valid_q || out_ready);

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = frame;
            out_count_d = count;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_deser_buffer.sv
// Self-checking bench for deser_buffer: frame-level queue model plus directed scenarios.
module tb_deser_buffer;

    localparam int W  = 8;
    localparam int D  = 5;
    localparam int CW = $clog2(D + 1);

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [W-1:0]    in_data = '0;
    logic            in_last = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [D*W-1:0]  out_data;
    logic [CW-1:0]   out_count;

    deser_buffer #(
        .width(W),
        .depth(D)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D*W-1:0] data;
        int             cnt;
    } frame_t;

    frame_t         exp_q[$];
    logic [D*W-1:0] cur_data;
    int             cur_len;
    int             checks = 0;
    int             failures = 0;
    int             popped = 0;
    int             low_ready = 0;
    int             high_valid = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        cur_data = '0;
        cur_len  = 0;
        exp_q.delete();
    endtask

    // An accepted word lands at position cur_len; a frame closes on last or when full.
    task automatic model_word(input logic [W-1:0] d, input bit last);
        frame_t f;
        cur_data[cur_len*W +: W] = d;
        cur_len++;
        if (last || cur_len == D) begin
            f.data = cur_data;
            f.cnt  = cur_len;
            exp_q.push_back(f);
            cur_data = '0;
            cur_len  = 0;
        end
    endtask

    task automatic send(input logic [W-1:0] d, input bit last, input int gap);
        bit ok;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        chk("send_accepted", 64'(ok), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (ok) model_word(d, last);
    endtask

    task automatic wait_out();
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_out_data"}, 64'(out_data), 64'd0);
        chk({tag, "_out_count"}, 64'(out_count), 64'd0);
    endtask

    // Compare process: every consumer handshake must deliver the next modelled frame,
    // and a stalled frame must stay put.
    initial begin
        bit             hold;
        logic [D*W-1:0] hold_data;
        logic [CW-1:0]  hold_cnt;
        frame_t         f;
        hold = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_data", 64'(out_data), 64'(hold_data));
                    chk("stall_count", 64'(out_count), 64'(hold_cnt));
                end
                if (!in_ready) low_ready++;
                if (out_valid) high_valid++;
                if (out_valid && out_ready) begin
                    chk("frame_expected", 64'(exp_q.size() > 0), 64'd1);
                    if (exp_q.size() > 0) begin
                        f = exp_q.pop_front();
                        chk("frame_data", 64'(out_data), 64'(f.data));
                        chk("frame_count", 64'(out_count), 64'(f.cnt));
                        popped++;
                    end
                end
                hold      = out_valid && !out_ready;
                hold_data = out_data;
                hold_cnt  = out_count;
            end
        end
    end

    initial begin
        model_reset();
        #2;
        chk_reset_state("por");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        // Reset mid-operation, with a frame parked in the output register.
        out_ready = 1'b0;
        send(8'h01, 1'b0, 0);
        send(8'h02, 1'b0, 0);
        send(8'h03, 1'b1, 0);
        send(8'h07, 1'b0, 0);
        repeat (2) @(posedge clk);
        #2;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        reset = 1'b0;
        #1;
        chk_reset_state("async");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        out_ready = 1'b1;

        // Full frame streamed back to back.
        @(posedge clk);
        #1;
        low_ready  = 0;
        high_valid = 0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 0);
        @(negedge clk);
        chk("t2_bubble_ready", 64'(in_ready), 64'd0);
        chk("t2_latency_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_data", 64'(out_data), 64'h0504030201);
        chk("t2_count", 64'(out_count), 64'd5);
        repeat (3) @(negedge clk);
        #1;
        chk("t2_ready_low_cycles", 64'(low_ready), 64'd1);
        chk("t2_valid_high_cycles", 64'(high_valid), 64'd1);

        // Early termination, then a new frame restarts at slot 0.
        @(posedge clk);
        #1;
        send(8'h0A, 1'b0, 0);
        send(8'h0B, 1'b0, 0);
        send(8'h0C, 1'b1, 0);
        @(negedge clk);
        chk("t3_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("t3_data", 64'(out_data), 64'h00000C0B0A);
        chk("t3_count", 64'(out_count), 64'd3);
        @(posedge clk);
        #1;
        send(8'h0D, 1'b0, 0);
        send(8'h0E, 1'b1, 0);
        wait_out();
        chk("t3b_data", 64'(out_data), 64'h0000000E0D);
        chk("t3b_count", 64'(out_count), 64'd2);

        // Backpressure: two frames buffered, then released back to back.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b0, 0);
        for (int i = 1; i <= 5; i++) send(8'(8'h10 + i), 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("t4_pend_ready", 64'(in_ready), 64'd0);
        chk("t4_held_valid", 64'(out_valid), 64'd1);
        chk("t4_held_data", 64'(out_data), 64'h0504030201);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_first_data", 64'(out_data), 64'h0504030201);
        @(negedge clk);
        chk("t4_no_gap_valid", 64'(out_valid), 64'd1);
        chk("t4_second_data", 64'(out_data), 64'h1514131211);
        @(negedge clk);
        chk("t4_drained_valid", 64'(out_valid), 64'd0);

        // Input gaps must not affect frame contents.
        @(posedge clk);
        #1;
        for (int i = 1; i <= 5; i++) send(8'(8'h20 + i), 1'b0, $urandom_range(0, 3));
        wait_out();
        chk("t5_data", 64'(out_data), 64'h2524232221);
        chk("t5_count", 64'(out_count), 64'd5);

        // Partial frame discarded by a one-cycle reset pulse.
        repeat (2) @(posedge clk);
        #1;
        send(8'h31, 1'b0, 0);
        send(8'h32, 1'b0, 0);
        reset = 1'b0;
        #1;
        chk_reset_state("pulse");
        model_reset();
        @(posedge clk);
        #1;
        reset  = 1'b1;
        popped = 0;
        for (int i = 1; i <= 5; i++) send(8'(8'h40 + i), 1'b0, 0);
        wait_out();
        chk("t6_data", 64'(out_data), 64'h4544434241);
        chk("t6_count", 64'(out_count), 64'd5);
        repeat (3) @(negedge clk);
        #1;
        chk("t6_frames_out", 64'(popped), 64'd1);
        chk("all_frames_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deser_buffer.md
# deser_buffer

Serial-to-parallel frame collector with valid/ready handshakes on both sides. It accepts `width`-bit words one at a time and assembles frames of up to `depth` words, with optional early termination. Each frame is presented as one packed `depth*width` vector. It sits directly downstream of the `shift_reg` delay stage and turns the delayed activation stream into parallel operand vectors for the MAC array. Double buffering, one collector plus one output register, lets a new frame fill while the previous one waits for the consumer.

## Interface
Parameters:
- `width`, 8, bits per word
- `depth`, 5, words per full frame (≥2)

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state immediately
- `in_valid`  in  1  upstream word valid
- `in_ready`  out  1  block can accept a word
- `in_data`  in  `width`  upstream word
- `in_last`  in  1  this word ends the frame early
- `out_valid`  out  1  packed frame available
- `out_ready`  in  1  consumer takes frame
- `out_data`  out  `depth*width`  packed frame; word k at bits [k*width +: width]
- `out_count`  out  `$clog2(depth+1)`  number of valid words in `out_data` (1..`depth`)

## Operation
- Handshake: a transfer occurs on a rising edge where valid and ready are both 1. Valid, once raised, holds with stable data until the transfer.
- The collector FSM has two states: FILL and PEND.
  - FILL: `in_ready`=1. An accepted word is written to slot `cnt`, then `cnt` increments.
  - If the accepted word has `in_last`=1, or `cnt` reaches `depth`, the next state is PEND.
  - PEND: `in_ready`=0. Frame complete, waiting to move to the output register.
- Transfer from PEND to output: occurs on the edge where `out_valid`=0 or `out_ready`=1.
  - Output register loads the collector slots and the count.
  - Collector slots and `cnt` clear to 0; state returns to FILL.
- Unused slots in a short frame read as 0.
- Words are 0-indexed: the first accepted word is word 0, at the LSBs.
- `in_ready` depends only on registered state, never combinationally on `out_ready`.
- If `in_last` is asserted on word `depth-1`, the result is the same as a full frame.
- Zero-length frames cannot occur. `in_last` without `in_valid` is ignored.
- Output register:
  - `out_valid` sets on a transfer.
  - It clears on an `out_ready` handshake when no new transfer happens on the same edge.
  - It stays 1 with new data when a consumer handshake and a collector transfer coincide.
- Reset, including mid-frame: all slots, `cnt`, `out_data`, `out_count` and `out_valid` go to 0, state goes to FILL, and `in_ready`=1. Any partial frame is discarded.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_count`=0.
- Latency: the final word of a frame is accepted at edge N. State is PEND after edge N. `out_valid`=1 after edge N+1, provided the output register is free or draining.
- Throughput: exactly one `in_ready` bubble per frame. A full frame therefore takes `depth`+1 cycles at best.
- Backpressure: while `out_valid`=1 and `out_ready`=0, the collector may fill one more frame and then sits in PEND. `out_data` and `out_count` stay stable; no words are lost or reordered.
- Simultaneous events: an `out_ready` handshake and a PEND transfer on the same edge produce back-to-back frames with no gap on `out_valid`.

## Structure
- Shared package `dnn_pkg`:
  - typedef `deser_state_t` {S_FILL, S_PEND}
  - function for count width, `$clog2(depth+1)`
- One natural sub-module, `deser_collector`. It holds the slot array, `cnt` and the FSM, and exposes a `done`/`take` pair. `deser_buffer` wraps it with the output register and handshake logic.
- All flops use async active-low reset. There is no other clock or reset domain.

## Test plan
All scenarios use `width`=8, `depth`=5.
1. Assert `reset`=0 mid-simulation → `in_ready`=1, `out_valid`=0, `out_data`=40'h0, `out_count`=0 immediately, without waiting for a clock edge.
2. Stream 01,02,03,04,05 with `in_valid`=1 and `out_ready`=1 → `out_data`=40'h0504030201, `out_count`=5, `out_valid` high 1 cycle. `in_ready` is low for exactly the cycle after 05 is accepted.
3. Send 0A,0B,0C with `in_last` on 0C → `out_data`=40'h00000C0B0A, `out_count`=3. A following frame starts at slot 0.
4. Hold `out_ready`=0 and send frames 01..05 then 11..15 → the first frame is held stable, the collector sits in PEND and `in_ready`=0. Release `out_ready` → frames emerge in order with no gap on `out_valid` and no loss.
5. Random `in_valid` gaps while sending 21..25 → `out_data`=40'h2524232221 and `out_count`=5, unaffected by the gaps.
6. Send 31,32, pulse `reset`=0 for 1 cycle, then send 41..45 → the partial frame is discarded and the only output is 40'h4544434241 with `out_count`=5.
